// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern pipeline: display geometry, the
// parameter-sequencer state type, colour type and power-on colour values.
package vga_pkg;

    // Visible raster size.
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 960;

    // Width of one gathered parameter field.
    localparam int FIELD_W = 4;

    // Slot of each parameter inside the gathered shadow set.
    localparam int FLD_SEL_A = 0;
    localparam int FLD_SEL_B = 1;
    localparam int FLD_R_A   = 2;
    localparam int FLD_G_A   = 3;
    localparam int FLD_B_A   = 4;
    localparam int FLD_R_B   = 5;
    localparam int FLD_G_B   = 6;
    localparam int FLD_B_B   = 7;

    // Parameter sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_READY  = 2'd2,
        ST_COMMIT = 2'd3
    } seq_state_t;

    // {r,g,b} colour, 4 bits per channel.
    typedef logic [11:0] color12_t;

    // Colours shown before any parameter set has been committed.
    localparam color12_t COL_A_RESET = 12'hFFF;
    localparam color12_t COL_B_RESET = 12'h000;

    // Assemble a colour from its three channel nibbles.
    function automatic color12_t pack_rgb(input logic [FIELD_W-1:0] r,
                                          input logic [FIELD_W-1:0] g,
                                          input logic [FIELD_W-1:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/frame_end_det.sv
// Frame-end detector: flags the cycle where display_en falls on the last
// active line. Shared by the pattern stages that update between frames.
module frame_end_det #(
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        display_en,
    input  logic [11:0] v_count,
    output logic        frame_end
);

    localparam logic [11:0] LAST_LINE = 12'(V_ACTIVE - 1);

    logic de_d;

    // Delay display_en one cycle so its falling edge can be seen.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            de_d <= 1'b0;
        end else begin
            de_d <= display_en;
        end
    end

    // Falling edge of the active region on the last visible line ends the frame.
    assign frame_end = de_d && !display_en && (v_count == LAST_LINE);

endmodule

// File: rtl/pattern_param_seq.sv
// Pattern parameter sequencer: on an update request it samples NUM_FIELDS
// random nibbles into a shadow set, waits for the end of the visible frame
// and then swaps the whole set into the live pattern parameters at once, so
// the picture never shows a half-updated parameter set.
module pattern_param_seq #(
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int NUM_FIELDS = 8
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        display_en,
    input  logic [11:0] v_count,
    input  logic        half_sec_pulse,
    input  logic [12:0] rnd_in,
    input  logic        freeze,
    output logic [3:0]  sel_a,
    output logic [3:0]  sel_b,
    output logic [11:0] col_a,
    output logic [11:0] col_b,
    output logic        params_valid,
    output logic        update_pulse,
    output logic [7:0]  frame_count,
    output logic        busy
);

    import vga_pkg::*;

    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    logic                frame_end;
    logic                request;
    seq_state_t          state_reg;
    seq_state_t          state_next;
    logic                pending_reg;
    logic                pending_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic [FIELD_W-1:0]  shadow [NUM_FIELDS];
    logic [3:0]          sel_a_reg;
    logic [3:0]          sel_b_reg;
    color12_t            col_a_reg;
    color12_t            col_b_reg;
    logic                params_valid_reg;
    logic                update_pulse_reg;
    logic                busy_reg;
    logic [7:0]          frame_count_reg;
    logic                unused_rnd;

    // Only the low nibble of the LFSR word is consumed per gather slot.
    assign unused_rnd = ^rnd_in[12:FIELD_W];

    // A frozen tempo pulse is simply not a request.
    assign request = half_sec_pulse && !freeze;

    frame_end_det #(
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_end_det (
        .clk_in     (clk_in),
        .reset      (reset),
        .display_en (display_en),
        .v_count    (v_count),
        .frame_end  (frame_end)
    );

    // Next-state, gather index and pending-request decisions.
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        idx_next     = '0;
        case (state_reg)
            ST_IDLE: begin
                if (request) begin
                    state_next = ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (request) begin
                    pending_next = 1'b1;
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_READY;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            ST_READY: begin
                // A request coinciding with the frame end is remembered for the next round.
                if (request) begin
                    pending_next = 1'b1;
                end
                if (frame_end) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (pending_reg || request) begin
                    state_next = ST_GATHER;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Starting a gather consumes every request seen so far; they collapse into it.
        if ((state_next == ST_GATHER) && (state_reg != ST_GATHER)) begin
            pending_next = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 1'b0;
            idx_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            idx_reg     <= idx_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_shadow
            logic [FIELD_W-1:0] field_reg;

            // Capture one random nibble into this field during its gather slot.
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    field_reg <= '0;
                end else if ((state_reg == ST_GATHER) && (idx_reg == IDX_W'(gi))) begin
                    field_reg <= rnd_in[FIELD_W-1:0];
                end
            end

            assign shadow[gi] = field_reg;
        end
    endgenerate

    // Live parameters change only when leaving COMMIT, all fields together.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sel_a_reg        <= '0;
            sel_b_reg        <= '0;
            col_a_reg        <= COL_A_RESET;
            col_b_reg        <= COL_B_RESET;
            params_valid_reg <= 1'b0;
            update_pulse_reg <= 1'b0;
        end else begin
            update_pulse_reg <= (state_reg == ST_COMMIT);
            if (state_reg == ST_COMMIT) begin
                sel_a_reg        <= shadow[FLD_SEL_A];
                sel_b_reg        <= shadow[FLD_SEL_B];
                col_a_reg        <= pack_rgb(shadow[FLD_R_A], shadow[FLD_G_A], shadow[FLD_B_A]);
                col_b_reg        <= pack_rgb(shadow[FLD_R_B], shadow[FLD_G_B], shadow[FLD_B_B]);
                params_valid_reg <= 1'b1;
            end
        end
    end

    // Completed-frame counter, wrapping naturally at 8 bits.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_count_reg <= '0;
        end else if (frame_end) begin
            frame_count_reg <= frame_count_reg + 8'd1;
        end
    end

    // Busy follows the state being entered so it lines up with GATHER/READY.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next == ST_GATHER) || (state_next == ST_READY);
        end
    end

    assign sel_a        = sel_a_reg;
    assign sel_b        = sel_b_reg;
    assign col_a        = col_a_reg;
    assign col_b        = col_b_reg;
    assign params_valid = params_valid_reg;
    assign update_pulse = update_pulse_reg;
    assign frame_count  = frame_count_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_pattern_param_seq.sv
// Bench for pattern_param_seq. Stimulus drives one cycle per step and feeds a
// time-stamp reference model: an accepted request at cycle s collects the
// random nibbles of cycles s+1..s+8, the set commits on the first frame end at
// or after s+9 and becomes visible two cycles after that frame end. Expected
// commits go into a scoreboard queue checked by an independent monitor.
module tb_pattern_param_seq;

    localparam int V_ACT = 960;
    localparam int NF    = 8;
    localparam int MAXC  = 16384;
    localparam logic [11:0] LAST_LINE = 12'(V_ACT - 1);

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        display_en = 1'b0;
    logic [11:0] v_count = 12'd0;
    logic        half_sec_pulse = 1'b0;
    logic [12:0] rnd_in = 13'd0;
    logic        freeze = 1'b0;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [11:0] col_a;
    logic [11:0] col_b;
    logic        params_valid;
    logic        update_pulse;
    logic [7:0]  frame_count;
    logic        busy;

    pattern_param_seq #(
        .V_ACTIVE   (V_ACT),
        .NUM_FIELDS (NF)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .display_en     (display_en),
        .v_count        (v_count),
        .half_sec_pulse (half_sec_pulse),
        .rnd_in         (rnd_in),
        .freeze         (freeze),
        .sel_a          (sel_a),
        .sel_b          (sel_b),
        .col_a          (col_a),
        .col_b          (col_b),
        .params_valid   (params_valid),
        .update_pulse   (update_pulse),
        .frame_count    (frame_count),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [11:0] ca;
        logic [11:0] cb;
        logic        pv;
        logic        up;
        logic        bz;
        logic [7:0]  fc;
    } view_t;

    typedef struct {
        int          cyc;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [11:0] ca;
        logic [11:0] cb;
    } commit_t;

    view_t      exp_view [MAXC];
    bit         exp_ok   [MAXC];
    logic [3:0] rnd_hist [MAXC];
    commit_t    sb_q[$];

    // Reference model state.
    int    cyc       = 0;
    int    start_cyc = -1;
    int    commit_fe = -1;
    bit    pend_seen = 1'b0;
    logic  m_de_prev = 1'b0;
    view_t m_view;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @t=%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic commit_t make_set(input int s, input int vis);
        commit_t c;
        c.cyc = vis;
        c.sa  = rnd_hist[s + 1];
        c.sb  = rnd_hist[s + 2];
        c.ca  = {rnd_hist[s + 3], rnd_hist[s + 4], rnd_hist[s + 5]};
        c.cb  = {rnd_hist[s + 6], rnd_hist[s + 7], rnd_hist[s + 8]};
        return c;
    endfunction

    // Predict the outputs of the next cycle from this cycle's inputs.
    function automatic void model_cycle(input logic rs, input logic de, input logic [11:0] vc,
                                        input logic hs, input logic fz);
        view_t   nv;
        commit_t c;
        bit      fe;
        bit      req;
        nv    = m_view;
        nv.up = 1'b0;
        if (rs) begin
            nv.sa = 4'h0; nv.sb = 4'h0; nv.ca = 12'hFFF; nv.cb = 12'h000;
            nv.pv = 1'b0; nv.bz = 1'b0; nv.fc = 8'd0;
            start_cyc = -1;
            commit_fe = -1;
            pend_seen = 1'b0;
            m_de_prev = 1'b0;
            while (sb_q.size() > 0 && sb_q[$].cyc > cyc) void'(sb_q.pop_back());
        end else begin
            fe  = m_de_prev && !de && (vc == LAST_LINE);
            req = hs && !fz;
            if (fe) nv.fc = m_view.fc + 8'd1;
            if (start_cyc < 0) begin
                if (req) begin
                    start_cyc = cyc;
                    pend_seen = 1'b0;
                end
            end else if (commit_fe >= 0 && cyc == commit_fe + 1) begin
                c     = make_set(start_cyc, cyc + 1);
                nv.sa = c.sa; nv.sb = c.sb; nv.ca = c.ca; nv.cb = c.cb;
                nv.pv = 1'b1;
                nv.up = 1'b1;
                commit_fe = -1;
                if (pend_seen || req) begin
                    start_cyc = cyc;
                    pend_seen = 1'b0;
                end else begin
                    start_cyc = -1;
                end
            end else begin
                if (req) pend_seen = 1'b1;
                if (fe && cyc >= start_cyc + NF + 1) begin
                    commit_fe = cyc;
                    sb_q.push_back(make_set(start_cyc, cyc + 2));
                end
            end
            nv.bz     = (start_cyc >= 0) && (commit_fe < 0);
            m_de_prev = de;
        end
        m_view = nv;
        if (cyc + 1 < MAXC) begin
            exp_view[cyc + 1] = nv;
            exp_ok[cyc + 1]   = 1'b1;
        end
    endfunction

    task automatic step(input logic rs, input logic de, input logic [11:0] vc,
                        input logic hs, input logic fz, input logic [12:0] r);
        reset          = rs;
        display_en     = de;
        v_count        = vc;
        half_sec_pulse = hs;
        freeze         = fz;
        rnd_in         = r;
        if (cyc < MAXC) rnd_hist[cyc] = r[3:0];
        model_cycle(rs, de, vc, hs, fz);
        cyc++;
        @(negedge clk_in);
    endtask

    // Monitor: per-cycle output check plus scoreboard pop on every update pulse.
    int mcyc = 0;
    always @(negedge clk_in) begin : monitor
        view_t   e;
        commit_t c;
        if (mcyc < MAXC && exp_ok[mcyc]) begin
            e = exp_view[mcyc];
            chk("sel_a",        32'(sel_a),        32'(e.sa));
            chk("sel_b",        32'(sel_b),        32'(e.sb));
            chk("col_a",        32'(col_a),        32'(e.ca));
            chk("col_b",        32'(col_b),        32'(e.cb));
            chk("params_valid", 32'(params_valid), 32'(e.pv));
            chk("update_pulse", 32'(update_pulse), 32'(e.up));
            chk("busy",         32'(busy),         32'(e.bz));
            chk("frame_count",  32'(frame_count),  32'(e.fc));
        end
        while (sb_q.size() > 0 && sb_q[0].cyc < mcyc) begin
            c = sb_q.pop_front();
            chk("commit_missing_at_cycle", 32'(mcyc), 32'(c.cyc));
        end
        if (update_pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse_queue_size", 32'd0, 32'd1);
            end else begin
                c = sb_q.pop_front();
                chk("commit_cycle", 32'(mcyc), 32'(c.cyc));
                chk("commit_sel_a", 32'(sel_a), 32'(c.sa));
                chk("commit_sel_b", 32'(sel_b), 32'(c.sb));
                chk("commit_col_a", 32'(col_a), 32'(c.ca));
                chk("commit_col_b", 32'(col_b), 32'(c.cb));
            end
        end
        mcyc++;
    end

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        logic [7:0]  fc_before;
        logic        rs;
        logic        de;
        logic        hs;
        logic        fz_mode;
        logic [11:0] vc;
        fz_mode = 1'b0;

        @(negedge clk_in);
        repeat (3) step(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 13'($urandom));

        // Quiet after reset: defaults must hold.
        repeat (100) step(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 13'($urandom));
        chk("idle_col_a", 32'(col_a), 32'h0FFF);
        chk("idle_col_b", 32'(col_b), 32'h0000);
        chk("idle_sel_a", 32'(sel_a), 32'h0);
        chk("idle_sel_b", 32'(sel_b), 32'h0);
        chk("idle_params_valid", 32'(params_valid), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Request at 10, nibbles 1..8 over 11..18, frame end at 40.
        for (int i = 0; i < 50; i++)
            step(1'b0, (i == 39), (i == 40) ? LAST_LINE : 12'd0, (i == 10), 1'b0,
                 (i >= 11 && i <= 18) ? 13'(i - 10) : 13'($urandom));
        chk("known_sel_a", 32'(sel_a), 32'h1);
        chk("known_sel_b", 32'(sel_b), 32'h2);
        chk("known_col_a", 32'(col_a), 32'h345);
        chk("known_col_b", 32'(col_b), 32'h678);
        chk("known_params_valid", 32'(params_valid), 32'h1);

        // Frame end during gather is ignored; commit at the following one.
        for (int i = 0; i < 60; i++)
            step(1'b0, (i == 3 || i == 39), (i == 4 || i == 40) ? LAST_LINE : 12'd0,
                 (i == 0), 1'b0, 13'($urandom));

        // Request coincident with frame end in READY, then a second commit.
        for (int i = 0; i < 70; i++)
            step(1'b0, (i == 19 || i == 49), (i == 20 || i == 50) ? LAST_LINE : 12'd0,
                 (i == 0 || i == 20), 1'b0, 13'($urandom));

        // Frozen requests over three frames.
        for (int i = 0; i < 100; i++)
            step(1'b0, (i % 30 == 29), (i % 30 == 0) ? LAST_LINE : 12'd0,
                 (i % 7 == 0), 1'b1, 13'($urandom));
        chk("frozen_busy", 32'(busy), 32'h0);

        // Freeze raised mid-gather must not abort the update.
        for (int i = 0; i < 40; i++)
            step(1'b0, (i == 29), (i == 30) ? LAST_LINE : 12'd0,
                 (i == 0 || i == 5), (i != 0), 13'($urandom));

        // 256 frame ends bring the counter back to where it started.
        fc_before = m_view.fc;
        for (int i = 0; i < 512; i++)
            step(1'b0, (i % 2 == 0), LAST_LINE, 1'b0, 1'b0, 13'($urandom));
        chk("frame_count_wrap", 32'(frame_count), 32'(fc_before));

        // Reset while READY discards the gathered set.
        for (int i = 0; i < 35; i++)
            step((i == 14), 1'b0, 12'd0, (i == 0), 1'b0, 13'($urandom));
        chk("rst_ready_col_a", 32'(col_a), 32'h0FFF);
        chk("rst_ready_params_valid", 32'(params_valid), 32'h0);
        chk("rst_ready_frame_count", 32'(frame_count), 32'h0);

        // Randomized soak.
        for (int i = 0; i < 5000; i++) begin
            rs = ($urandom_range(0, 499) == 0);
            de = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: vc = LAST_LINE;
                4:          vc = LAST_LINE - 12'd1;
                5:          vc = LAST_LINE + 12'd1;
                default:    vc = 12'($urandom);
            endcase
            hs = ($urandom_range(0, 19) == 0);
            if (i % 400 == 0) fz_mode = ($urandom_range(0, 3) == 0);
            step(rs, de, vc, hs, fz_mode, 13'($urandom));
        end

        // Drain: no new requests, let any outstanding commit land.
        for (int i = 0; i < 6; i++)
            step(1'b0, (i == 1), (i == 2) ? LAST_LINE : 12'd0, 1'b0, 1'b0, 13'($urandom));
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_param_seq.md
PATTERN_PARAM_SEQ -- requirements
Module: pattern_param_seq

Interface
REQ-001 Parameter V_ACTIVE, default 960: number of active lines per frame.
REQ-002 Parameter NUM_FIELDS, default 8: number of 4-bit fields gathered per update.
REQ-003 clk_in  in  1  pixel clock; the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 display_en  in  1  active-pixel flag from the timing generator.
REQ-006 v_count  in  12  current line number from the timing generator.
REQ-007 half_sec_pulse  in  1  one-cycle update request from the tempo block.
REQ-008 rnd_in  in  13  free-running LFSR word that advances every clock.
REQ-009 freeze  in  1  when high, suppresses new update requests.
REQ-010 sel_a, sel_b  out  4 each  bit-index selectors for the pattern stage.
REQ-011 col_a, col_b  out  12 each  {r,g,b} colour sets A and B, 4 bits per channel.
REQ-012 params_valid  out  1  high once the first commit has occurred.
REQ-013 update_pulse  out  1  one-cycle pulse in the cycle after a commit.
REQ-014 frame_count  out  8  count of completed frames.
REQ-015 busy  out  1  high in GATHER or READY.

Function
REQ-016 frame_end SHALL be 1 in cycle N when de_d=1, display_en=0 and v_count==V_ACTIVE-1.
  - de_d is display_en registered one cycle.
REQ-017 frame_count SHALL increment by 1 on every frame_end and wrap from 255 to 0.
REQ-018 The FSM SHALL have four states: IDLE, GATHER, READY, COMMIT.
REQ-019 IDLE -> GATHER on half_sec_pulse=1 with freeze=0.
  - half_sec_pulse=1 with freeze=1 SHALL be ignored.
REQ-020 GATHER SHALL last exactly NUM_FIELDS cycles, index 0..7.
  - Each cycle stores rnd_in[3:0] into shadow field[index].
  - Field order: sel_a, sel_b, r_a, g_a, b_a, r_b, g_b, b_b.
  - GATHER -> READY after index 7.
REQ-021 READY -> COMMIT on frame_end.
  - A frame_end seen during GATHER SHALL NOT commit; the commit waits for the next frame_end in READY.
REQ-022 COMMIT SHALL last one cycle and copy the whole shadow into the active outputs atomically.
  - Outputs SHALL show the new values from the cycle after COMMIT.
  - update_pulse=1 in that same cycle; params_valid set to 1.
REQ-023 pending flag behaviour:
  - Set by half_sec_pulse (freeze=0) arriving in GATHER, READY or COMMIT.
  - COMMIT -> GATHER if pending=1, else COMMIT -> IDLE.
  - pending cleared on entry to GATHER.
  - Multiple requests SHALL collapse into one.
REQ-024 Simultaneous half_sec_pulse and frame_end in READY SHALL commit and set pending.
REQ-025 Active outputs SHALL never change except in the cycle after COMMIT or on reset.
  - No partial or mid-frame update is allowed.
REQ-026 freeze asserted while in GATHER or READY SHALL NOT abort the update in progress.

Reset
REQ-027 On reset=1 at a clock edge, all state SHALL take these values in the next cycle, regardless of current state:
  - state=IDLE, pending=0, shadow=0, de_d=0.
  - sel_a=0, sel_b=0, col_a=12'hFFF, col_b=12'h000.
  - params_valid=0, update_pulse=0, frame_count=0, busy=0.
REQ-028 Reset during GATHER or READY SHALL discard the shadow contents with no commit.

Structure
REQ-029 Shared package vga_pkg SHALL hold:
  - H_ACTIVE=1280 and V_ACTIVE=960 constants;
  - the FSM state enum;
  - the 12-bit colour type;
  - the reset colour constants.
REQ-030 frame_end and de_d SHALL live in one sub-module, frame_end_det, reused by other pattern stages.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-032 Scenario: reset, then idle 100 cycles -> col_a=FFF, col_b=000, sel=0, params_valid=0, busy=0.
REQ-033 Scenario: half_sec at cycle 10, rnd_in[3:0]=1..8 over cycles 11-18, frame_end at cycle 40 ->
  - sel_a=1, sel_b=2, col_a=345, col_b=678;
  - update_pulse at cycle 42 only.
REQ-034 Scenario: frame_end during GATHER -> no change; commit occurs at the following frame_end.
REQ-035 Scenario: half_sec and frame_end coincident in READY -> commit, then immediate GATHER; second commit at the next frame.
REQ-036 Scenario: freeze=1 with half_sec pulses -> state stays IDLE; outputs unchanged over 3 frames.
REQ-037 Scenario: 256 frame_ends -> frame_count wraps to 0; reset asserted in READY -> defaults restored, no update_pulse.
